// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one SRAM-like bus between fetch (I) and mem stage (D).
// Optional watchdog on the DATA phase: define MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [3:0]  d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        bus_req,
    output logic [3:0]  bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    localparam int SW_RAW = $clog2(MAX_D_STREAK + 1);
    localparam int SW     = (SW_RAW < 3) ? 3 : SW_RAW;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]    state;
    logic          grant_d;
    logic [SW-1:0] streak;
    logic [3:0]    wen_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          pick_d;
    logic          tmo;
    logic          fin;

    // D wins unless I has waited through a full D streak
    assign pick_d = d_req && !(i_req && (streak == STREAK_MAX));

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd;

    // Watchdog: counts DATA cycles, restarts on every address acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd <= '0;
        end else if (state == S_ADDR && bus_addr_ok) begin
            wd <= '0;
        end else if (state == S_DATA) begin
            wd <= wd + 1'b1;
        end
    end

    assign tmo = (state == S_DATA) && !bus_data_ok
               && (wd == WW'(TIMEOUT_CYCLES));
`else
    assign tmo = 1'b0;
`endif

    assign fin       = (state == S_DATA) && (bus_data_ok || tmo);
    assign i_done    = fin && !grant_d;
    assign d_done    = fin && grant_d;
    assign i_rdata   = tmo ? 32'h0 : bus_rdata;
    assign d_rdata   = tmo ? 32'h0 : bus_rdata;
    assign bus_err   = tmo;
    assign bus_req   = (state == S_ADDR);
    assign bus_wen   = wen_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

    // Main FSM plus latched copy of the granted request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            grant_d <= 1'b1;
            wen_q   <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        state   <= S_ADDR;
                        grant_d <= pick_d;
                        wen_q   <= pick_d ? d_wen : 4'h0;
                        addr_q  <= pick_d ? d_addr : i_addr;
                        wdata_q <= pick_d ? d_wdata : 32'h0;
                    end
                end
                S_ADDR: begin
                    if (bus_addr_ok) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (fin) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Streak of D grants taken while I was waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (state == S_IDLE) begin
            if (!i_req || !pick_d) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a simple memory responder.
// Timeout section runs only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req = 0, d_req = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic [3:0]  d_wen = 0;
    logic        i_done, d_done, bus_req, bus_err;
    logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_wen;
    logic        bus_addr_ok = 0, bus_data_ok = 0;
    logic [31:0] bus_rdata = 32'hDEAD_DEAD;

    mem_bus_arbiter #(.MAX_D_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_d;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0, n_err = 0;
    int cyc = 0, ni = 0, nd = 0, last_done_cyc = 0, req_cyc = 0;
    int adly = 0, ddly = 0, data_cyc = 0;
    bit nodata = 0;
    int bad = 0, acyc = 0;
    logic [31:0] cap_addr = 0, cap_wdata = 0;
    logic [3:0]  cap_wen = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hCAFE_BBBE;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: addr_ok after adly cycles of bus_req, data_ok after ddly
    initial begin : responder
        int ph, cnt;
        ph = 0; cnt = 0;
        forever begin
            @(negedge clk);
            bus_addr_ok = 0;
            bus_data_ok = 0;
            bus_rdata   = 32'hDEAD_DEAD;
            if (!rst) begin
                ph = 0; cnt = 0;
            end else if (ph == 0) begin
                if (bus_req) begin
                    if (cnt >= adly) begin
                        bus_addr_ok = 1;
                        cap_addr = bus_addr;
                        cap_wen = bus_wen;
                        cap_wdata = bus_wdata;
                        data_cyc = cyc + 1;
                        ph = 1; cnt = 0;
                    end else cnt++;
                end
            end else if (nodata) begin
                cnt++;
                if (cnt > 12) begin ph = 0; cnt = 0; end
            end else if (cnt >= ddly) begin
                bus_data_ok = 1;
                bus_rdata = memf(cap_addr);
                ph = 0; cnt = 0;
            end else cnt++;
        end
    end

    // Monitor: pops scoreboard on every done pulse
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (i_done || d_done) begin
                chk("single_done", 32'(i_done & d_done), 32'd0);
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("grantee", 32'(d_done), 32'(e.is_d));
                    chk("rdata", d_done ? d_rdata : i_rdata, e.rdata);
                    chk("err", 32'(bus_err), 32'(e.err));
                end
                last_done_cyc = cyc;
                if (d_done) nd++; else ni++;
            end else if (bus_err) begin
                chk("err_without_done", 32'(i_done | d_done), 32'd1);
            end
        end
    end

    task automatic txn(input bit is_d, input logic [31:0] a,
                       input logic [3:0] w, input logic [31:0] wd,
                       input int ad, input int dd, input bit drop,
                       input bit exp_err);
        int k, tgt;
        exp_t e;
        @(negedge clk); #3;
        adly = ad; ddly = dd;
        e.is_d = is_d;
        e.err = exp_err;
        e.rdata = exp_err ? 32'h0 : memf(a);
        sb.push_back(e);
        tgt = ni + nd + 1;
        req_cyc = cyc; bad = 0; acyc = 0;
        if (is_d) begin
            d_req = 1; d_addr = a; d_wen = w; d_wdata = wd;
        end else begin
            i_req = 1; i_addr = a;
        end
        k = 0;
        while (ni + nd < tgt && k < 100) begin
            @(negedge clk); #3;
            k++;
            if (bus_req) begin
                acyc++;
                if ({bus_addr, bus_wen, bus_wdata} !==
                    {a, is_d ? w : 4'h0, is_d ? wd : 32'h0}) bad++;
                if (drop) begin d_req = 0; i_req = 0; end
            end
        end
        chk("done_in_time", 32'(ni + nd >= tgt), 32'd1);
        d_req = 0; i_req = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench stuck");
    end

    initial begin : stim
        int k, tgt, n0;
        exp_t e;
        rst = 0;
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_wen", 32'(bus_wen), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_dones", 32'({i_done, d_done, bus_err}), 32'd0);
        repeat (2) @(negedge clk);
        #3 rst = 1;

        // single load, minimum latency
        txn(1, 32'h100, 4'h0, 32'h0, 0, 0, 0, 0);
        chk("load_lat", 32'(last_done_cyc - req_cyc), 32'd2);
        chk("load_addr", cap_addr, 32'h100);
        chk("load_wen", 32'(cap_wen), 32'd0);

        // store
        n0 = ni;
        txn(1, 32'h204, 4'b0100, 32'h00AB_0000, 0, 0, 0, 0);
        chk("store_wen", 32'(cap_wen), 32'b0100);
        chk("store_wdata", cap_wdata, 32'h00AB_0000);
        chk("store_no_i", 32'(ni), 32'(n0));

        // back-pressure
        n0 = ni + nd;
        txn(1, 32'h300, 4'b0011, 32'h1234_5678, 5, 3, 0, 0);
        chk("bp_stable", 32'(bad), 32'd0);
        chk("bp_addr_cycles", 32'(acyc), 32'd6);
        chk("bp_lat", 32'(last_done_cyc - req_cyc), 32'd10);
        repeat (4) @(negedge clk);
        chk("bp_one_done", 32'(ni + nd - n0), 32'd1);

        // fetch with bus_* check for I grant
        txn(0, 32'h0000_0400, 4'hF, 32'hFFFF_FFFF, 1, 2, 0, 0);
        chk("ifetch_bus_ok", 32'(bad), 32'd0);

        // requester drops req mid-transaction
        txn(1, 32'h700, 4'h0, 32'h0, 2, 1, 1, 0);

        // reset mid-DATA
        @(negedge clk); #3;
        adly = 0; ddly = 1000;
        d_req = 1; d_addr = 32'h500; d_wen = 4'h0;
        repeat (4) @(negedge clk);
        #3 rst = 0;
        #1;
        chk("midrst_bus_req", 32'(bus_req), 32'd0);
        chk("midrst_bus_addr", bus_addr, 32'd0);
        chk("midrst_done", 32'({i_done, d_done}), 32'd0);
        d_req = 0;
        repeat (2) @(negedge clk);
        #3 rst = 1;
        ddly = 0;
        txn(0, 32'h600, 4'h0, 32'h0, 0, 0, 0, 0);
        chk("post_rst_lat", 32'(last_done_cyc - req_cyc), 32'd2);

        // contention: D,D,D,D,I repeated
        @(negedge clk); #3;
        adly = 0; ddly = 0;
        for (int j = 0; j < 10; j++) begin
            e.is_d = (j % 5) != 4;
            e.err = 0;
            e.rdata = memf(e.is_d ? 32'h2000 : 32'h1000);
            sb.push_back(e);
        end
        tgt = ni + nd + 10;
        i_addr = 32'h1000; d_addr = 32'h2000; d_wen = 0; d_wdata = 0;
        i_req = 1; d_req = 1;
        k = 0;
        while (ni + nd < tgt && k < 100) begin
            @(negedge clk); #3;
            k++;
        end
        i_req = 0; d_req = 0;
        chk("contention_done", 32'(ni + nd >= tgt), 32'd1);
        repeat (4) @(negedge clk);
        chk("contention_sb", 32'(sb.size()), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        nodata = 1;
        txn(0, 32'h40, 4'h0, 32'h0, 0, 0, 0, 1);
        chk("tmo_lat", 32'(last_done_cyc - data_cyc), 32'd8);
        repeat (14) @(negedge clk);
        nodata = 0;
        txn(1, 32'h44, 4'h0, 32'h0, 0, 0, 0, 0);
`endif

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
